// File: rtl/sample_packet_tx.sv
// Packs 3-bit samples five per 16-bit word, buffers the words in a FIFO and
// frames them as header/sequence/payload packets on a valid/ready word stream.
module sample_packet_tx #(
    parameter int          PAYLOAD_WORDS = 256,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] HEADER_WORD   = 16'hA5C3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [2:0]  sample_data,
    output logic        word_valid,
    output logic [15:0] word_data,
    input  logic        word_ready,
    output logic        pkt_start,
    output logic        pkt_end,
    output logic        overflow,
    output logic [8:0]  pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [8:0]    LAST_IDX = 9'(PAYLOAD_WORDS - 1);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, PAY} state_t;

    logic [2:0]  slot_q, slot_d;
    logic [11:0] pack_q, pack_d;
    logic        push_q, push_d;
    logic [15:0] push_word_q, push_word_d;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_after_pop;
    logic          overflow_q, overflow_d;
    logic          pop, push_ok;
    logic [15:0]   head_next;

    state_t      state_q, state_d;
    logic        word_valid_q, word_valid_d;
    logic [15:0] word_data_q, word_data_d;
    logic        pkt_start_q, pkt_start_d;
    logic        pkt_end_q, pkt_end_d;
    logic [8:0]  pay_cnt_q, pay_cnt_d;
    logic [8:0]  seq_q, seq_d;
    logic        xfer;

    // Slots 0..3 accumulate in pack_q; the fifth sample completes the word directly.
    always_comb begin
        slot_d      = slot_q;
        pack_d      = pack_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        if (!enable) begin
            slot_d = 3'd0;
        end else if (sample_valid) begin
            if (slot_q == 3'd4) begin
                push_d      = 1'b1;
                push_word_d = {1'b0, sample_data, pack_q};
                slot_d      = 3'd0;
            end else begin
                case (slot_q)
                    3'd0:    pack_d[2:0]  = sample_data;
                    3'd1:    pack_d[5:3]  = sample_data;
                    3'd2:    pack_d[8:6]  = sample_data;
                    3'd3:    pack_d[11:9] = sample_data;
                    default: pack_d       = pack_q;
                endcase
                slot_d = slot_q + 3'd1;
            end
        end
    end

    // The FIFO head is the word on the bus during payload, so a pop is a payload transfer.
    always_comb begin
        xfer          = word_valid_q && word_ready;
        pop           = (state_q == PAY) && xfer;
        push_ok       = push_q && ((cnt_q != DEPTH_C) || pop);
        overflow_d    = overflow_q | (push_q & ~push_ok);
        cnt_d         = cnt_q + CW'(push_ok) - CW'(pop);
        cnt_after_pop = cnt_q - CW'(pop);
        wr_ptr_d      = wr_ptr_q + AW'(push_ok);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        head_next     = (cnt_after_pop != '0) ? mem_q[rd_ptr_d] : push_word_q;
    end

    always_comb begin
        state_d      = state_q;
        word_valid_d = word_valid_q;
        word_data_d  = word_data_q;
        pkt_start_d  = pkt_start_q;
        pkt_end_d    = pkt_end_q;
        pay_cnt_d    = pay_cnt_q;
        seq_d        = seq_q;
        case (state_q)
            IDLE: begin
                word_valid_d = 1'b0;
                word_data_d  = 16'h0000;
                pkt_start_d  = 1'b0;
                pkt_end_d    = 1'b0;
                if (cnt_q != '0) begin
                    state_d      = HDR;
                    word_valid_d = 1'b1;
                    word_data_d  = HEADER_WORD;
                    pkt_start_d  = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d     = SEQ;
                    word_data_d = {7'b0, seq_q};
                    pkt_start_d = 1'b0;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_d      = PAY;
                    pay_cnt_d    = 9'd0;
                    word_valid_d = (cnt_d != '0);
                    word_data_d  = head_next;
                    pkt_end_d    = (LAST_IDX == 9'd0);
                end
            end
            PAY: begin
                if (xfer && (pay_cnt_q == LAST_IDX)) begin
                    state_d      = IDLE;
                    word_valid_d = 1'b0;
                    word_data_d  = 16'h0000;
                    pkt_end_d    = 1'b0;
                    seq_d        = seq_q + 9'd1;
                end else begin
                    if (xfer) begin
                        pay_cnt_d = pay_cnt_q + 9'd1;
                    end
                    word_valid_d = (cnt_d != '0);
                    word_data_d  = head_next;
                    pkt_end_d    = (pay_cnt_d == LAST_IDX);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q       <= 3'd0;
            pack_q       <= 12'h000;
            push_q       <= 1'b0;
            push_word_q  <= 16'h0000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            state_q      <= IDLE;
            word_valid_q <= 1'b0;
            word_data_q  <= 16'h0000;
            pkt_start_q  <= 1'b0;
            pkt_end_q    <= 1'b0;
            pay_cnt_q    <= 9'd0;
            seq_q        <= 9'd0;
        end else begin
            slot_q       <= slot_d;
            pack_q       <= pack_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            pkt_start_q  <= pkt_start_d;
            pkt_end_q    <= pkt_end_d;
            pay_cnt_q    <= pay_cnt_d;
            seq_q        <= seq_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_end    = pkt_end_q;
    assign overflow   = overflow_q;
    assign pkt_count  = seq_q;

endmodule
